// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared state encoding and constants for the sequential BCD converter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL    = 3;

    // Bit counter runs IN_W-1 down to 0
    function automatic int cnt_width(input int in_w);
        return (in_w > 1) ? $clog2(in_w) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_add3.sv
// ============================================================================
// Module  : bcd_add3
// Brief   : Double-dabble digit corrector: adds 3 to any digit of 5 or more.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(ADD3_THRESH)) begin
            digit_o = digit_i + BCD_DIGIT_W'(ADD3_VAL);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_conv_seq.sv
// ============================================================================
// Module  : bcd_conv_seq
// Brief   : One-bit-per-clock binary-to-BCD converter with start/busy/done
//           handshake and overflow flag. Define BCD_SIGNED_EN for signed input.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic                            out_en_i,
    input  logic [IN_W-1:0]                 bin_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_o,
    output logic                            ovf_o,
    output logic                            neg_o
);

    localparam int CNT_W = cnt_width(IN_W);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               neg_q, neg_d;

    logic               w_sign;
    logic [IN_W-1:0]    w_mag;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W-1:0]   w_work_nxt;
    logic               w_ovf_nxt;

`ifdef BCD_SIGNED_EN
    // Magnitude as IN_W-bit unsigned, so the most negative value stays exact
    assign w_sign = bin_i[IN_W-1];
    assign w_mag  = w_sign ? (~bin_i + IN_W'(1)) : bin_i;
`else
    assign w_sign = 1'b0;
    assign w_mag  = bin_i;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (w_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Bit leaving the top digit is a carry worth 10^DIGITS
    assign w_work_nxt = {w_corr[BCD_W-2:0], shift_q[IN_W-1]};
    assign w_ovf_nxt  = ovf_acc_q | w_corr[BCD_W-1];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        sign_d    = sign_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        neg_d     = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shift_d   = w_mag;
                    sign_d    = w_sign;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = CNT_W'(IN_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d   = {shift_q[IN_W-2:0], 1'b0};
                work_d    = w_work_nxt;
                ovf_acc_d = w_ovf_nxt;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bcd_d   = w_work_nxt;
                    ovf_d   = w_ovf_nxt;
                    neg_d   = sign_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            neg_q     <= neg_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = out_en_i ? bcd_q : '0;
    assign ovf_o  = ovf_q;
    assign neg_o  = neg_q;

endmodule

`default_nettype wire

// File: doc/bcd_conv_seq.md
Name: bcd_conv_seq

Overview:
Multi-cycle, parametrised binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. It is the sequential successor of the combinational display converter. It sits between the ALU result register and the 7-segment decoders. Adds a start/busy/done handshake, arbitrary input width and digit count, and an overflow flag.

Parameters:
IN_W, 32, input binary width in bits (>=4)
DIGITS, 10, number of BCD output digits (>=1); 10 covers full 32-bit unsigned range

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start_i  input  1  request conversion; sampled only in IDLE
out_en_i  input  1  display enable; 0 forces bcd_o to all-zero (combinational mask, state unaffected)
bin_i  input  IN_W  binary value, captured on accepted start
busy_o  output  1  high while conversion in progress
done_o  output  1  one-cycle pulse when bcd_o/ovf_o/neg_o update
bcd_o  output  4*DIGITS  packed digits, digit 0 (units) in [3:0]
ovf_o  output  1  value >= 10^DIGITS; bcd_o holds value mod 10^DIGITS
neg_o  output  1  sign of converted value (see Optional Feature)

Behaviour:
- Reset (async, rst=1): state IDLE; busy_o=0, done_o=0, bcd_o=0, ovf_o=0, neg_o=0; shift/work registers cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: start_i=1 at edge k -> capture bin_i into shift reg, clear work digits, clear ovf accumulator, load bit counter with IN_W-1, go to SHIFT. busy_o=1 from cycle k+1.
- SHIFT: each cycle, every work digit >=5 gets +3 (4-bit, via sub-module). Then the concatenation {digits, shift reg} shifts left by 1. Bit shifted out of the top digit's bit 3 is ORed into the ovf accumulator. Counter decrements; when it reaches 0, go to DONE. Exactly IN_W cycles spent in SHIFT.
- DONE: bcd_o, ovf_o, neg_o registered from work state; done_o=1 for this single cycle; busy_o=0 in DONE; return to IDLE.
- Latency: start accepted at edge k -> done_o high in cycle k+IN_W+1; new result visible in the same cycle.
- bcd_o/ovf_o/neg_o hold the last result until the next DONE; intermediate shift state is never visible.
- start_i while SHIFT or DONE: ignored, not queued. start_i held high continuously gives back-to-back conversions every IN_W+2 cycles.
- bin_i changes after capture have no effect on the running conversion.
- Reset mid-conversion: aborts immediately; outputs return to reset values; no done_o.
- Overflow: when DIGITS is insufficient (e.g. IN_W=16, DIGITS=4, value 12345), ovf_o=1 and bcd_o=2345.
- out_en_i=0 masks bcd_o only; done_o, ovf_o, neg_o are unaffected.

Optional Feature:
BCD_SIGNED_EN:
- Defined: bin_i is two's complement. On capture, the magnitude (|bin_i|, IN_W bits unsigned, so -2^(IN_W-1) is exact) is loaded and the sign bit is latched. neg_o reflects the sign at DONE. Result -0 is impossible.
- Undefined: bin_i is unsigned and neg_o is tied to 0. The port remains present.

Decomposition:
- Package bcd_pkg: state encoding (IDLE/SHIFT/DONE), BCD_DIGIT_W=4, ADD3_THRESH=5, ADD3_VAL=3, function giving counter width $clog2(IN_W).
- Sub-module bcd_add3: 4-bit combinational digit corrector (in>=5 ? in+3 : in). Instantiated DIGITS times via generate.

Test Plan:
- Reset then idle: after rst deasserts, bcd_o=0, ovf_o=0, busy_o=0, done_o never pulses without start.
- Defaults, bin_i=32'd4294967295, start pulse -> done_o exactly 33 cycles after the accept edge; bcd_o digits = 4294967295; ovf_o=0.
- IN_W=16, DIGITS=4, bin_i=16'd9999 -> bcd_o=16'h9999, ovf_o=0. Then bin_i=16'd12345 -> bcd_o=16'h2345, ovf_o=1.
- start_i asserted again during SHIFT, and bin_i changed mid-conversion -> single done_o; result matches the originally captured value (e.g. 1234 -> 16'h1234).
- rst pulsed at SHIFT cycle 5 -> outputs zero immediately; no done_o. A fresh start with 0 gives bcd_o=0 after IN_W+1 cycles.
- BCD_SIGNED_EN, IN_W=16, DIGITS=5, bin_i=16'h8000 -> neg_o=1, bcd_o=20'h32768. bin_i=-1 -> neg_o=1, bcd_o=1. With out_en_i=0, bcd_o reads 0 while neg_o stays 1.
